// File: rtl/mem_pkg.sv
// mem_pkg: size/state encodings and the alignment rule shared by the load/store unit.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? a[0] : a != 2'b00;
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication/strobes and load byte-lane extraction with extension.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] ldata
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = rdata[{addr[1], 4'b0000} +: 16];
    assign wstrb = size == SZ_BYTE ? 4'b0001 << addr :
                   size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_lane = size == SZ_BYTE ? {4{wdata[7:0]}} :
                        size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    assign ldata = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                   size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage load/store unit driving a two-phase (address, data) SRAM-like bus.
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              hold,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       load_data,
    output logic              mem_stall,
    output logic              addr_err,
    output logic              bus_err
);
    state_t          state;
    logic [TO_W-1:0] cnt;
    logic            mis, issue, to;
    logic [3:0]      strb;
    logic [31:0]     lane, ld;
    mem_align u_align (
        .size(req_size), .addr(req_addr[1:0]), .sgn(req_signed), .wdata(req_wdata),
        .rdata(data_rdata), .wstrb(strb), .wdata_lane(lane), .ldata(ld)
    );
    assign mis        = misaligned(req_size, req_addr[1:0]);
    assign addr_err   = req_valid & mis;
    assign issue      = ~rst & (state == ST_IDLE) & req_valid & ~mis;
    assign data_req   = issue | (state == ST_ADDR);
    assign data_wr    = data_req & req_we;
    assign data_size  = data_req ? req_size : 2'b00;
    assign data_addr  = data_req ? req_addr : '0;
    assign data_wdata = data_req ? lane : 32'd0;
    assign data_wstrb = data_wr ? strb : 4'b0000;
    assign mem_stall  = issue | (state == ST_ADDR) | (state == ST_DATA);
    // to marks the TIMEOUT-th consecutive cycle in ADDR or DATA
    assign to         = cnt == TO_W'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            load_data <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (issue) begin
                    state <= data_addr_ok ? ST_DATA : ST_ADDR;
                    cnt   <= '0;
                end
                ST_ADDR: if (data_addr_ok) begin
                    state <= ST_DATA;
                    cnt   <= '0;
                end else if (to) begin
                    state     <= ST_DONE;
                    cnt       <= '0;
                    bus_err   <= 1'b1;
                    load_data <= 32'd0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_DATA: if (data_data_ok) begin
                    state <= ST_DONE;
                    cnt   <= '0;
                    if (!req_we) load_data <= ld;
                end else if (to) begin
                    state     <= ST_DONE;
                    cnt       <= '0;
                    bus_err   <= 1'b1;
                    load_data <= 32'd0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: if (!hold) begin
                    state   <= ST_IDLE;
                    bus_err <= 1'b0;
                end
            endcase
        end
    end
endmodule
